rgb_fade_ctrl: RTL and testbench
================================

Name: rgb_fade_ctrl

Overview:
Colour sequencer that generates the three PWM inputs for the on-chip RGB LED current driver (RGB0PWM..RGB2PWM) and its enable (RGBLEDEN/CURREN).
A host issues colour commands over a valid/ready handshake. Each command either applies immediately or fades linearly from the current colour.
PWM duty updates are glitch-free: new duties are applied only at PWM period boundaries.

Parameters:
PWM_W, 8, duty/PWM counter width; PWM period = 2^PWM_W ticks
PRESCALE, 16, clk cycles per PWM tick (>=1)
STEP_DIV, 256, PWM periods per fade step (>=1)

Ports:
clk  in  1  system clock (HFOSC domain)
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept; high only in IDLE
cmd_rgb  in  3*PWM_W  target colour {R,G,B}, R in MSBs
cmd_fade  in  1  1 = fade to target, 0 = apply immediately
busy  out  1  fade in progress
cur_rgb  out  3*PWM_W  current linear colour {R,G,B}
pwm  out  3  per-channel PWM: [0]=R, [1]=G, [2]=B
led_en  out  1  driver enable

Behaviour:
- Reset (rst_n low at posedge):
  - prescaler, pwm_cnt, step_cnt, cur, target, and latched duties clear to 0.
  - pwm = 3'b000, led_en = 0, state = IDLE, so cmd_ready = 1 and busy = 0.
  - A reset mid-fade aborts the fade the same way; nothing is retained.
- Prescaler: counts 0..PRESCALE-1. tick is asserted on the cycle it equals PRESCALE-1, then it wraps to 0.
- pwm_cnt: PWM_W bits, increments on tick, wraps 2^PWM_W-1 -> 0.
  - period_end = tick && pwm_cnt == all-ones.
- Duty latch: at period_end, each channel's active duty is loaded from cur, or from gamma(cur) when the optional feature is enabled. Between period ends the active duty is stable.
- pwm[i] is registered: pwm[i] <= (pwm_cnt < duty_i).
  - duty 0 gives constant low.
  - duty 2^PWM_W-1 gives high for all but one tick per period; 100% duty is not possible by design.
- FSM states: IDLE, FADE.
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready:
    - cmd_fade = 0: cur <= cmd_rgb at that edge; cur_rgb shows the new value the next cycle. Stay in IDLE.
    - cmd_fade = 1 and cmd_rgb != cur: target <= cmd_rgb, step_cnt <= 0, go to FADE.
    - cmd_fade = 1 and cmd_rgb == cur: accepted as a no-op; stay in IDLE.
  - FADE: cmd_ready = 0 and busy = 1. cmd_valid is ignored; the host holds it until ready.
    - step_cnt advances on each period_end.
    - At the period_end where step_cnt == STEP_DIV-1: step_cnt <= 0, and each channel moves one LSB toward its target (+1, -1, or hold). Each channel is saturation-free because it stops at its target.
    - When all channels equal target after a step, go to IDLE. cmd_ready rises the next cycle.
  - Maximum fade length = (2^PWM_W-1) * STEP_DIV periods.
- led_en: registered, = busy || (cur != 0).
- Timing: new duties take effect on pwm at the first period_end after cur changes, plus 1 cycle of output register.

Optional Feature:
RGB_GAMMA_EN
- Defined: duty_i = (c*c + 2^PWM_W-1) >> PWM_W, computed at full 2*PWM_W width. Reference points: 0->0, 1->1, 128->64, 255->255 at PWM_W=8. cur_rgb still reports the linear value.
- Undefined: duty_i = c_i.

Decomposition:
- Package rgb_fade_pkg:
  - state typedef (IDLE, FADE)
  - channel index constants CH_R=0, CH_G=1, CH_B=2
  - field offset helpers for the {R,G,B} packing
- Sub-module rgb_pwm_chan, instantiated 3x. Contains the duty latch at period_end, the optional gamma map, and the registered compare against a shared pwm_cnt.
- The prescaler, pwm_cnt, step_cnt and FSM stay in the top module.

Test Plan:
Use PWM_W=8, PRESCALE=2, STEP_DIV=2 unless stated.
1. Reset mid-fade: assert rst_n=0 for 1 cycle during FADE -> next cycle pwm=0, cur_rgb=0, busy=0, cmd_ready=1, led_en=0.
2. Immediate command: cmd_rgb=0x80_00_FF, cmd_fade=0.
   - Next cycle: cur_rgb=0x8000FF, led_en=1.
   - Over one full period after the next period_end: pwm[0] high 128 ticks (256 clk), pwm[1] never high, pwm[2] high 255 ticks.
3. Fade 0x000000 -> 0x030001:
   - busy for exactly 3 steps (6 periods); cur_rgb sequence 0x010001, 0x020001, 0x030001.
   - cmd_ready low throughout, then high 1 cycle after the final step.
4. Fade down plus blocked command: fade 0x0A0A0A -> 0x000000 while a second cmd_valid is held.
   - Second command is not accepted until IDLE, then accepted on the first cmd_ready cycle.
   - After the fade completes, led_en falls to 0.
5. Same-colour fade: cmd_fade=1 with cmd_rgb == cur -> accepted, busy stays 0, no state change.
6. RGB_GAMMA_EN defined, cur R = 128 -> pwm[0] high 64 ticks per period. Undefined -> 128 ticks.

Source files
------------

// File: rtl/rgb_fade_pkg.sv
// Shared types and helpers for the RGB fade controller.
package rgb_fade_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FADE = 1'b1
   } state_e;

   localparam int NUM_CH = 3;
   localparam int CH_R   = 0;
   localparam int CH_G   = 1;
   localparam int CH_B   = 2;

   // Colours are packed {R,G,B} with red in the MSBs, so channel 0 sits highest.
   function automatic int chanLsb(input int ch, input int width);
      return (NUM_CH - 1 - ch) * width;
   endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: duty latched at period boundaries, registered compare output.
// Optional gamma mapping of the duty is enabled with `define RGB_GAMMA_EN.
module rgb_pwm_chan #(
   parameter int PWM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             period_end_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   input  logic [PWM_W-1:0] level_i,
   output logic             pwm_o
);

   logic [PWM_W-1:0] duty_d;
   logic [PWM_W-1:0] duty_q;
   logic             pwm_q;

`ifdef RGB_GAMMA_EN
   // Rounded-up square keeps level 1 visible and maps full scale onto itself.
   logic [2*PWM_W-1:0] sq;
   assign sq     = {{PWM_W{1'b0}}, level_i} * {{PWM_W{1'b0}}, level_i}
                 + {{PWM_W{1'b0}}, {PWM_W{1'b1}}};
   assign duty_d = PWM_W'(sq >> PWM_W);
`else
   assign duty_d = level_i;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         if (period_end_i) begin
            duty_q <= duty_d;
         end
         pwm_q <= (pwm_cnt_i < duty_q);
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_fade_ctrl.sv
// RGB LED colour sequencer: host commands set or linearly fade the colour.
// Build with `define RGB_GAMMA_EN to gamma-map the PWM duties.
module rgb_fade_ctrl
   import rgb_fade_pkg::*;
#(
   parameter int PWM_W    = 8,
   parameter int PRESCALE = 16,
   parameter int STEP_DIV = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3*PWM_W-1:0] cmd_rgb,
   input  logic               cmd_fade,
   output logic               busy,
   output logic [3*PWM_W-1:0] cur_rgb,
   output logic [2:0]         pwm,
   output logic               led_en
);

   localparam int RGB_W = 3 * PWM_W;
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SD_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [PS_W-1:0]  presc_q;
   logic [PWM_W-1:0] pwm_cnt_q;
   logic [SD_W-1:0]  step_q;
   logic [RGB_W-1:0] cur_q;
   logic [RGB_W-1:0] target_q;
   logic [RGB_W-1:0] step_rgb;
   state_e           state_q;
   logic             ready_q;
   logic             busy_q;
   logic             led_en_q;
   logic             tick;
   logic             period_end;

   assign tick       = (presc_q == PS_W'(PRESCALE - 1));
   assign period_end = tick && (&pwm_cnt_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + PS_W'(1);
         if (tick) begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
         end
      end
   end

   // Each channel moves one LSB toward its target and holds once it arrives.
   always_comb begin
      step_rgb = cur_q;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (cur_q[chanLsb(ch, PWM_W) +: PWM_W] < target_q[chanLsb(ch, PWM_W) +: PWM_W]) begin
            step_rgb[chanLsb(ch, PWM_W) +: PWM_W] = cur_q[chanLsb(ch, PWM_W) +: PWM_W] + PWM_W'(1);
         end else if (cur_q[chanLsb(ch, PWM_W) +: PWM_W] > target_q[chanLsb(ch, PWM_W) +: PWM_W]) begin
            step_rgb[chanLsb(ch, PWM_W) +: PWM_W] = cur_q[chanLsb(ch, PWM_W) +: PWM_W] - PWM_W'(1);
         end
      end
   end

   // led_en is updated from the values being loaded so it tracks cur_rgb without lag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         target_q <= '0;
         step_q   <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         led_en_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid && ready_q) begin
                  if (!cmd_fade) begin
                     cur_q    <= cmd_rgb;
                     led_en_q <= (cmd_rgb != '0);
                  end else if (cmd_rgb != cur_q) begin
                     target_q <= cmd_rgb;
                     step_q   <= '0;
                     state_q  <= FADE;
                     ready_q  <= 1'b0;
                     busy_q   <= 1'b1;
                     led_en_q <= 1'b1;
                  end
               end
            end
            FADE: begin
               if (period_end) begin
                  if (step_q == SD_W'(STEP_DIV - 1)) begin
                     step_q <= '0;
                     cur_q  <= step_rgb;
                     if (step_rgb == target_q) begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        led_en_q <= (step_rgb != '0);
                     end
                  end else begin
                     step_q <= step_q + SD_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
      rgb_pwm_chan #(
         .PWM_W(PWM_W)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .period_end_i(period_end),
         .pwm_cnt_i   (pwm_cnt_q),
         .level_i     (cur_q[chanLsb(ch, PWM_W) +: PWM_W]),
         .pwm_o       (pwm[ch])
      );
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign cur_rgb   = cur_q;
   assign led_en    = led_en_q;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Self-checking bench for rgb_fade_ctrl: command table, fades, PWM duty and reset.
module tb_rgb_fade_ctrl;

   localparam int PWM_W      = 8;
   localparam int PRESCALE   = 2;
   localparam int STEP_DIV   = 2;
   localparam int PERIOD_CLK = (1 << PWM_W) * PRESCALE;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_fade  = 1'b0;
   logic [23:0] cmd_rgb   = '0;
   logic        cmd_ready;
   logic        busy;
   logic        led_en;
   logic [23:0] cur_rgb;
   logic [2:0]  pwm;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [23:0] rgb;
      logic        fade;
      logic [23:0] expCur;
      logic        expLed;
   } vec_t;

   vec_t        vecs[7];
   vec_t        vecQ[$];
   logic [23:0] curQ[$];

   rgb_fade_ctrl #(
      .PWM_W   (PWM_W),
      .PRESCALE(PRESCALE),
      .STEP_DIV(STEP_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_rgb  (cmd_rgb),
      .cmd_fade (cmd_fade),
      .busy     (busy),
      .cur_rgb  (cur_rgb),
      .pwm      (pwm),
      .led_en   (led_en)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one command and returns 1ns after the edge that accepted it.
   task automatic applyStimulus(input logic [23:0] rgb, input logic fade);
      int n;
      n         = 0;
      cmd_rgb   = rgb;
      cmd_fade  = fade;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 40000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("handshake", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Follows a fade until busy drops, comparing every cur_rgb change against curQ.
   task automatic watchFade(input string tag, input int bound, output int busyCycles);
      logic [23:0] last;
      int          readyBad;
      int          n;
      last       = cur_rgb;
      readyBad   = 0;
      busyCycles = 0;
      n          = 0;
      while (busy === 1'b1 && n < bound) begin
         if (cmd_ready !== 1'b0) readyBad++;
         busyCycles++;
         @(posedge clk);
         #1;
         n++;
         if (cur_rgb !== last) begin
            if (curQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL %s extra step: got 0x%0h expected no change", tag, cur_rgb);
            end else begin
               checkOutput({tag, " step"}, {8'd0, cur_rgb}, {8'd0, curQ.pop_front()});
            end
            last = cur_rgb;
         end
      end
      checkOutput({tag, " finished in bound"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " ready low while busy"}, readyBad, 0);
      checkOutput({tag, " steps missing"}, curQ.size(), 0);
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        v;
      int          bc;
      int          cnt[3];
      int          expR;
      logic [7:0]  kb;

      vecs[0] = '{24'h8000FF, 1'b0, 24'h8000FF, 1'b1};
      vecs[1] = '{24'h8000FF, 1'b1, 24'h8000FF, 1'b1};
      vecs[2] = '{24'h000000, 1'b0, 24'h000000, 1'b0};
      vecs[3] = '{24'h000000, 1'b1, 24'h000000, 1'b0};
      vecs[4] = '{24'h123456, 1'b0, 24'h123456, 1'b1};
      vecs[5] = '{24'hFFFFFF, 1'b0, 24'hFFFFFF, 1'b1};
      vecs[6] = '{24'h000001, 1'b0, 24'h000001, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset cur", {8'd0, cur_rgb}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("reset led_en", {31'd0, led_en}, 32'd0);
      checkOutput("reset pwm", {29'd0, pwm}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Immediate and same-colour commands, scoreboarded in order.
      for (int i = 0; i < 7; i++) begin
         vecQ.push_back(vecs[i]);
         applyStimulus(vecs[i].rgb, vecs[i].fade);
         v = vecQ.pop_front();
         checkOutput($sformatf("vec%0d cur", i), {8'd0, cur_rgb}, {8'd0, v.expCur});
         checkOutput($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
         checkOutput($sformatf("vec%0d ready", i), {31'd0, cmd_ready}, 32'd1);
         checkOutput($sformatf("vec%0d led_en", i), {31'd0, led_en}, {31'd0, v.expLed});
      end

      // PWM duty over one full period once the new duty is latched.
      applyStimulus(24'h8000FF, 1'b0);
      repeat (PERIOD_CLK + 4) @(posedge clk);
      cnt = '{0, 0, 0};
      for (int t = 0; t < PERIOD_CLK; t++) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < 3; c++) cnt[c] += int'(pwm[c]);
      end
`ifdef RGB_GAMMA_EN
      expR = 64 * PRESCALE;
`else
      expR = 128 * PRESCALE;
`endif
      checkOutput("pwm R high clocks", cnt[0], expR);
      checkOutput("pwm G high clocks", cnt[1], 0);
      checkOutput("pwm B high clocks", cnt[2], 255 * PRESCALE);

      // Fade up 0x000000 -> 0x030001.
      applyStimulus(24'h000000, 1'b0);
      curQ.push_back(24'h010001);
      curQ.push_back(24'h020001);
      curQ.push_back(24'h030001);
      applyStimulus(24'h030001, 1'b1);
      checkOutput("fadeUp busy", {31'd0, busy}, 32'd1);
      checkOutput("fadeUp led_en", {31'd0, led_en}, 32'd1);
      watchFade("fadeUp", 8 * PERIOD_CLK, bc);
      checkOutput($sformatf("fadeUp length %0d in range", bc),
                  {31'd0, (bc > 5 * PERIOD_CLK) && (bc <= 6 * PERIOD_CLK)}, 32'd1);
      checkOutput("fadeUp ready after", {31'd0, cmd_ready}, 32'd1);
      checkOutput("fadeUp final cur", {8'd0, cur_rgb}, 32'h030001);

      // Fade down with a second command held the whole time.
      applyStimulus(24'h0A0A0A, 1'b0);
      for (int k = 9; k >= 0; k--) begin
         kb = 8'(k);
         curQ.push_back({kb, kb, kb});
      end
      applyStimulus(24'h000000, 1'b1);
      cmd_rgb   = 24'h00FF00;
      cmd_fade  = 1'b0;
      cmd_valid = 1'b1;
      watchFade("fadeDown", 24 * PERIOD_CLK, bc);
      checkOutput($sformatf("fadeDown length %0d in range", bc),
                  {31'd0, (bc > 19 * PERIOD_CLK) && (bc <= 20 * PERIOD_CLK)}, 32'd1);
      checkOutput("fadeDown ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("fadeDown led_en off", {31'd0, led_en}, 32'd0);
      checkOutput("fadeDown cur zero", {8'd0, cur_rgb}, 32'd0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checkOutput("held cmd accepted", {8'd0, cur_rgb}, 32'h00FF00);
      checkOutput("held cmd led_en", {31'd0, led_en}, 32'd1);

      // Reset in the middle of a fade.
      applyStimulus(24'h000000, 1'b0);
      applyStimulus(24'h050505, 1'b1);
      repeat (3 * PERIOD_CLK) @(posedge clk);
      #1;
      checkOutput("midfade busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("midreset cur", {8'd0, cur_rgb}, 32'd0);
      checkOutput("midreset busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("midreset led_en", {31'd0, led_en}, 32'd0);
      checkOutput("midreset pwm", {29'd0, pwm}, 32'd0);
      repeat (2 * PERIOD_CLK) @(posedge clk);
      #1;
      checkOutput("after reset stays idle", {31'd0, busy}, 32'd0);
      checkOutput("after reset pwm low", {29'd0, pwm}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
